cp0_exception_ctrl: RTL and testbench
=====================================

Name: cp0_exception_ctrl

Overview:
- Coprocessor-0 exception controller for the P7 five-stage MIPS pipeline.
- Collects the hardware interrupt lines and the per-instruction exception codes, and holds the SR, Cause and EPC registers.
- Drives the Req redirect that sends fetch to the 0x0000_4180 handler.
- Supplies mfc0 read data and the eret return address (EPCOut) back to the pipeline.

Parameters:
- HANDLER_ADDR, 32'h0000_4180: handler entry address; exported on HandlerPC for the fetch stage.
- INT_WIDTH, 6: number of hardware interrupt lines.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  one clock; reset is asynchronous and active-low.
- A1  input  5  mfc0 read register number.
- A2  input  5  mtc0 write register number.
- DIn  input  32  mtc0 write data.
- WE  input  1  mtc0 write enable, from the M stage.
- VPC  input  32  PC of the instruction in the M stage.
- BDIn  input  1  M-stage instruction sits in a branch delay slot.
- ExcCodeIn  input  5  M-stage exception code; 0 means none.
- HWInt  input  INT_WIDTH  level-sensitive interrupt lines.
- EXLClr  input  1  eret executing in the M stage.
- DOut  output  32  mfc0 read data (combinational on A1).
- EPCOut  output  32  current EPC value.
- HandlerPC  output  32  constant HANDLER_ADDR.
- Req  output  1  exception/interrupt taken this cycle (combinational).

Behaviour:
- Registers, with unused bits read as 0:
  - SR (12): IM[15:10], EXL[1], IE[0].
  - Cause (13): BD[31], IP[15:10], ExcCode[6:2].
  - EPC (14): 32 bits.
- Reset: reset=0 immediately clears SR, Cause and EPC; Req=0, DOut=0 for every A1, EPCOut=0.
- IntReq = IE & ~EXL & |(HWInt & IM).
- ExcReq = (ExcCodeIn != 0) & ~EXL.
- Req = IntReq | ExcReq; it settles in the same cycle its inputs change.
- Interrupts win over exceptions when both are present.
- On a rising edge with Req=1:
  - EXL <= 1.
  - BD <= BDIn.
  - ExcCode <= IntReq ? 0 : ExcCodeIn.
  - EPC <= BDIn ? VPC-4 : VPC, computed as 32-bit wrap-around subtraction.
  - Any mtc0 write and any EXLClr in the same cycle are discarded.
- IP <= HWInt on every rising edge while reset=1, independent of Req.
- On a rising edge with Req=0 and WE=1:
  - A2=12 loads IM, EXL and IE from DIn.
  - A2=14 loads EPC from DIn.
  - A2=13, or any other number, is ignored; Cause is not software-writable.
- EXLClr=1 with Req=0 clears EXL on that edge. If the same cycle also carries an mtc0 write to SR, EXLClr wins for the EXL bit only.
- Nested exceptions: while EXL=1, Req stays 0 even with a nonzero ExcCodeIn or an enabled interrupt.
- DOut:
  - A1=12 returns SR; A1=13 returns Cause; A1=14 returns EPC; any other number returns 0.
  - DOut shows the pre-edge value; there is no internal bypass of a same-cycle write.
- EPCOut is EPC directly; the pipeline's eret path selects it.
- Reset asserted mid-operation overrides everything at once, including a pending Req. After release, the first rising edge behaves as a normal cycle.

Test Plan:
- Reset then read: hold reset=0, release, A1=12/13/14 -> DOut=0 each time, Req=0.
- mtc0 SR then interrupt:
  - Write DIn=32'h0000_0401 to A2=12; then raise HWInt=6'b000001 -> Req=1 that cycle.
  - Next edge: EXL=1, Cause=32'h0000_0400 (ExcCode 0), EPC=VPC=32'h0000_3010.
- Delay-slot exception: ExcCodeIn=5'd4, BDIn=1, VPC=32'h0000_3024 -> EPC=32'h0000_3020, Cause[31]=1, Cause[6:2]=4.
- Nested suppression and eret:
  - With EXL=1, ExcCodeIn=5'd10 -> Req=0 and registers unchanged.
  - Pulse EXLClr -> EXL=0; the next ExcCodeIn=5'd10 gives Req=1.
- Priority and conflict: IE=1, IM=6'b111111, HWInt=6'b100000, ExcCodeIn=5'd12, WE=1 writing A2=14 -> ExcCode=0 and EPC=VPC (the write is dropped).
- Asynchronous reset mid-request: while Req=1, drive reset=0 between edges -> Req falls with no clock edge and all registers read 0.

Source files
------------

// File: rtl/cp0_exception_ctrl_if.sv
// Pipeline-facing signal bundle of the CP0 exception controller.
// The master side is the pipeline (M stage); the slave side is the controller.
interface cp0_exception_ctrl_if #(
   parameter int INT_WIDTH = 6
);
   logic [4:0]           A1;
   logic [4:0]           A2;
   logic [31:0]          DIn;
   logic                 WE;
   logic [31:0]          VPC;
   logic                 BDIn;
   logic [4:0]           ExcCodeIn;
   logic [INT_WIDTH-1:0] HWInt;
   logic                 EXLClr;
   logic [31:0]          DOut;
   logic [31:0]          EPCOut;
   logic [31:0]          HandlerPC;
   logic                 Req;

   modport master (
      output A1, A2, DIn, WE, VPC, BDIn, ExcCodeIn, HWInt, EXLClr,
      input  DOut, EPCOut, HandlerPC, Req
   );

   modport slave (
      input  A1, A2, DIn, WE, VPC, BDIn, ExcCodeIn, HWInt, EXLClr,
      output DOut, EPCOut, HandlerPC, Req
   );
endinterface

// File: rtl/cp0_exception_ctrl.sv
// Coprocessor-0 exception controller: SR/Cause/EPC, interrupt and exception
// arbitration, handler redirect request, mfc0 read port and eret return address.
module cp0_exception_ctrl #(
   parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
   parameter int          INT_WIDTH    = 6
) (
   input logic                clk,
   input logic                reset,
   cp0_exception_ctrl_if.slave bus
);

   localparam logic [4:0] REG_SR    = 5'd12;
   localparam logic [4:0] REG_CAUSE = 5'd13;
   localparam logic [4:0] REG_EPC   = 5'd14;

   // Architectural state
   logic [INT_WIDTH-1:0] im_r;
   logic                 exl_r;
   logic                 ie_r;
   logic                 bd_r;
   logic [INT_WIDTH-1:0] ip_r;
   logic [4:0]           exc_code_r;
   logic [31:0]          epc_r;

   // Next-state values
   logic [INT_WIDTH-1:0] im_nxt_s;
   logic                 exl_nxt_s;
   logic                 ie_nxt_s;
   logic                 bd_nxt_s;
   logic [4:0]           exc_code_nxt_s;
   logic [31:0]          epc_nxt_s;

   logic                 int_req_s;
   logic                 exc_req_s;
   logic                 req_s;
   logic                 sr_wr_s;
   logic                 epc_wr_s;
   logic [31:0]          sr_s;
   logic [31:0]          cause_s;
   logic [31:0]          dout_s;
   logic                 unused_s;

   // Request arbitration; Req is forced low while reset is asserted
   always_comb begin
      int_req_s = ie_r & ~exl_r & (|(bus.HWInt & im_r));
      exc_req_s = (bus.ExcCodeIn != 5'd0) & ~exl_r;
      req_s     = reset & (int_req_s | exc_req_s);
      sr_wr_s   = bus.WE & (bus.A2 == REG_SR);
      epc_wr_s  = bus.WE & (bus.A2 == REG_EPC);
   end

   // Next-state selection: a taken request drops any same-cycle mtc0 or eret
   always_comb begin
      im_nxt_s       = im_r;
      exl_nxt_s      = exl_r;
      ie_nxt_s       = ie_r;
      bd_nxt_s       = bd_r;
      exc_code_nxt_s = exc_code_r;
      epc_nxt_s      = epc_r;
      if (req_s) begin
         exl_nxt_s      = 1'b1;
         bd_nxt_s       = bus.BDIn;
         exc_code_nxt_s = int_req_s ? 5'd0 : bus.ExcCodeIn;
         epc_nxt_s      = bus.BDIn ? (bus.VPC - 32'd4) : bus.VPC;
      end else begin
         if (sr_wr_s) begin
            im_nxt_s  = bus.DIn[10 +: INT_WIDTH];
            exl_nxt_s = bus.DIn[1];
            ie_nxt_s  = bus.DIn[0];
         end else begin
            im_nxt_s  = im_r;
         end
         // eret overrides only the EXL bit of a concurrent SR write
         if (bus.EXLClr) begin
            exl_nxt_s = 1'b0;
         end else begin
            exl_nxt_s = exl_nxt_s;
         end
         if (epc_wr_s) begin
            epc_nxt_s = bus.DIn;
         end else begin
            epc_nxt_s = epc_r;
         end
      end
   end

   // State registers with asynchronous active-low clear
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         im_r       <= {INT_WIDTH{1'b0}};
         exl_r      <= 1'b0;
         ie_r       <= 1'b0;
         bd_r       <= 1'b0;
         ip_r       <= {INT_WIDTH{1'b0}};
         exc_code_r <= 5'd0;
         epc_r      <= 32'd0;
      end else begin
         im_r       <= im_nxt_s;
         exl_r      <= exl_nxt_s;
         ie_r       <= ie_nxt_s;
         bd_r       <= bd_nxt_s;
         ip_r       <= bus.HWInt;
         exc_code_r <= exc_code_nxt_s;
         epc_r      <= epc_nxt_s;
      end
   end

   // Architectural views of SR and Cause with unused bits held at zero
   always_comb begin
      sr_s                     = 32'd0;
      sr_s[10 +: INT_WIDTH]    = im_r;
      sr_s[1]                  = exl_r;
      sr_s[0]                  = ie_r;
      cause_s                  = 32'd0;
      cause_s[31]              = bd_r;
      cause_s[10 +: INT_WIDTH] = ip_r;
      cause_s[6:2]             = exc_code_r;
   end

   // mfc0 read mux; shows pre-edge contents with no write bypass
   always_comb begin
      case (bus.A1)
         REG_SR:    dout_s = sr_s;
         REG_CAUSE: dout_s = cause_s;
         REG_EPC:   dout_s = epc_r;
         default:   dout_s = 32'd0;
      endcase
   end

   assign bus.DOut      = dout_s;
   assign bus.EPCOut    = epc_r;
   assign bus.HandlerPC = HANDLER_ADDR;
   assign bus.Req       = req_s;

   // DIn bits outside the SR fields are never stored
   assign unused_s = ^{bus.DIn[31:10+INT_WIDTH], bus.DIn[9:2]};

endmodule

// File: tb/tb_cp0_exception_ctrl.sv
// Self-checking bench for cp0_exception_ctrl: word-level register model plus
// directed vectors with literal expectations.
module tb_cp0_exception_ctrl;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   errors = 0;
   logic chk_en = 1'b0;

   logic [31:0] m_sr = 32'd0;
   logic [31:0] m_cause = 32'd0;
   logic [31:0] m_epc = 32'd0;

   cp0_exception_ctrl_if #(.INT_WIDTH(6)) bus ();

   cp0_exception_ctrl #(
      .HANDLER_ADDR(32'h0000_4180),
      .INT_WIDTH(6)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic m_int();
      return m_sr[0] && !m_sr[1] && ((bus.HWInt & m_sr[15:10]) != 6'd0);
   endfunction

   function automatic logic m_req();
      logic exc;
      exc = (bus.ExcCodeIn != 5'd0) && !m_sr[1];
      return reset && (m_int() || exc);
   endfunction

   function automatic logic [31:0] m_dout(input logic [4:0] a);
      if (a == 5'd12) return m_sr;
      if (a == 5'd13) return m_cause;
      if (a == 5'd14) return m_epc;
      return 32'd0;
   endfunction

   always @(negedge reset) begin
      m_sr    = 32'd0;
      m_cause = 32'd0;
      m_epc   = 32'd0;
   end

   always @(posedge clk) begin
      logic take, intr;
      if (reset) begin
         take = m_req();
         intr = m_int();
         if (take) begin
            m_sr[1]      = 1'b1;
            m_cause      = 32'd0;
            m_cause[31]  = bus.BDIn;
            m_cause[6:2] = intr ? 5'd0 : bus.ExcCodeIn;
            m_epc        = bus.VPC - (bus.BDIn ? 32'd4 : 32'd0);
         end else begin
            if (bus.WE && bus.A2 == 5'd12) m_sr = bus.DIn & 32'h0000_FC03;
            if (bus.EXLClr) m_sr[1] = 1'b0;
            if (bus.WE && bus.A2 == 5'd14) m_epc = bus.DIn;
         end
         m_cause[15:10] = bus.HWInt;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("req", {31'd0, bus.Req}, {31'd0, m_req()});
         chk("dout", bus.DOut, m_dout(bus.A1));
         chk("epcout", bus.EPCOut, m_epc);
         chk("handlerpc", bus.HandlerPC, 32'h0000_4180);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.A2 = 5'd0; bus.DIn = 32'd0; bus.WE = 1'b0; bus.VPC = 32'd0;
      bus.BDIn = 1'b0; bus.ExcCodeIn = 5'd0; bus.HWInt = 6'd0; bus.EXLClr = 1'b0;
   endtask

   task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string nm);
      bus.A1 = a;
      #1;
      chk(nm, bus.DOut, exp);
   endtask

   task automatic req_is(input logic exp, input string nm);
      #1;
      chk(nm, {31'd0, bus.Req}, {31'd0, exp});
   endtask

   initial begin
      bus.A1 = 5'd0;
      idle();
      bus.ExcCodeIn = 5'd5;
      bus.HWInt = 6'h3f;
      #1;
      chk_en = 1'b1;
      repeat (2) cyc();
      req_is(1'b0, "req_in_reset");
      idle();
      cyc();
      reset = 1'b1;
      rd(5'd12, 32'd0, "sr_after_reset");
      rd(5'd13, 32'd0, "cause_after_reset");
      rd(5'd14, 32'd0, "epc_after_reset");
      cyc();

      // mtc0 SR then interrupt
      bus.WE = 1'b1; bus.A2 = 5'd12; bus.DIn = 32'h0000_0401;
      cyc();
      idle();
      rd(5'd12, 32'h0000_0401, "sr_written");
      bus.HWInt = 6'b000001; bus.VPC = 32'h0000_3010;
      req_is(1'b1, "req_interrupt");
      cyc();
      rd(5'd12, 32'h0000_0403, "sr_exl_set");
      rd(5'd13, 32'h0000_0400, "cause_interrupt");
      rd(5'd14, 32'h0000_3010, "epc_interrupt");

      // eret, then delay-slot exception
      bus.HWInt = 6'd0; bus.EXLClr = 1'b1;
      req_is(1'b0, "req_during_exl");
      cyc();
      idle();
      rd(5'd12, 32'h0000_0401, "sr_after_eret");
      bus.ExcCodeIn = 5'd4; bus.BDIn = 1'b1; bus.VPC = 32'h0000_3024;
      req_is(1'b1, "req_delay_slot");
      cyc();
      idle();
      rd(5'd14, 32'h0000_3020, "epc_delay_slot");
      rd(5'd13, 32'h8000_0010, "cause_delay_slot");
      rd(5'd12, 32'h0000_0403, "sr_delay_slot");

      // nested suppression and software writes while EXL
      bus.ExcCodeIn = 5'd10; bus.VPC = 32'h0000_3030;
      req_is(1'b0, "req_nested");
      cyc();
      idle();
      rd(5'd14, 32'h0000_3020, "epc_nested_kept");
      rd(5'd13, 32'h8000_0010, "cause_nested_kept");
      bus.WE = 1'b1; bus.A2 = 5'd13; bus.DIn = 32'hFFFF_FFFF;
      cyc();
      bus.A2 = 5'd14; bus.DIn = 32'h1234_5678;
      cyc();
      idle();
      rd(5'd13, 32'h8000_0010, "cause_not_writable");
      rd(5'd14, 32'h1234_5678, "epc_mtc0");
      rd(5'd5, 32'd0, "other_reg_zero");

      // eret re-enables exceptions
      bus.EXLClr = 1'b1;
      cyc();
      idle();
      bus.ExcCodeIn = 5'd10; bus.VPC = 32'h0000_3040;
      req_is(1'b1, "req_after_eret");
      cyc();
      idle();
      rd(5'd13, 32'h0000_0028, "cause_exc10");
      rd(5'd14, 32'h0000_3040, "epc_exc10");

      // SR write with concurrent eret: eret owns EXL
      bus.WE = 1'b1; bus.A2 = 5'd12; bus.DIn = 32'hFFFF_FFFF; bus.EXLClr = 1'b1;
      cyc();
      idle();
      rd(5'd12, 32'h0000_FC01, "sr_write_vs_eret");

      // interrupt beats exception, EPC write dropped
      bus.HWInt = 6'b100000; bus.ExcCodeIn = 5'd12; bus.WE = 1'b1; bus.A2 = 5'd14;
      bus.DIn = 32'hDEAD_BEEF; bus.VPC = 32'h0000_3050;
      req_is(1'b1, "req_priority");
      cyc();
      idle();
      rd(5'd13, 32'h0000_8000, "cause_priority");
      rd(5'd14, 32'h0000_3050, "epc_write_dropped");
      rd(5'd12, 32'h0000_FC03, "sr_priority");

      // EPC wrap-around in a delay slot
      bus.EXLClr = 1'b1;
      cyc();
      idle();
      bus.ExcCodeIn = 5'd1; bus.BDIn = 1'b1; bus.VPC = 32'h0000_0002;
      req_is(1'b1, "req_wrap");
      cyc();
      idle();
      rd(5'd14, 32'hFFFF_FFFE, "epc_wrap");
      rd(5'd13, 32'h8000_0004, "cause_wrap");

      // asynchronous reset while a request is pending
      bus.EXLClr = 1'b1;
      cyc();
      idle();
      bus.ExcCodeIn = 5'd3;
      req_is(1'b1, "req_before_async_reset");
      #1 reset = 1'b0;
      req_is(1'b0, "req_async_reset");
      chk("epcout_async_reset", bus.EPCOut, 32'd0);
      rd(5'd12, 32'd0, "sr_async_reset");
      rd(5'd13, 32'd0, "cause_async_reset");
      bus.ExcCodeIn = 5'd0;
      cyc();
      reset = 1'b1;
      rd(5'd14, 32'd0, "epc_async_reset");
      bus.WE = 1'b1; bus.A2 = 5'd14; bus.DIn = 32'hCAFE_0000;
      cyc();
      idle();
      rd(5'd14, 32'hCAFE_0000, "epc_first_edge_after_reset");
      repeat (2) cyc();

      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
